// File: rtl/cpu_sram_arbiter.sv
// rtl/cpu_sram_arbiter.sv - inst/data SRAM-like arbiter with order FIFO; ARB_RR_EN selects round-robin priority
module cpu_sram_arbiter #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_en,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        sram_en,
  output logic        sram_wr,
  output logic [1:0]  sram_size,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata
);

  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] fifo_q, fifo_d;
  logic             lock_q, lock_d;
  logic             lock_id_q, lock_id_d;
  logic             sel, full, push, pop, head, locked_en;
`ifdef ARB_RR_EN
  logic             rr_last_q, rr_last_d;
`endif

  // Owner selection: a held lock wins, then a lone requester, then the tie-break policy.
  always_comb begin
    sel = 1'b0;
    if (lock_q) begin
      sel = lock_id_q;
    end else if (inst_sram_en && data_sram_en) begin
`ifdef ARB_RR_EN
      sel = ~rr_last_q;
`else
      sel = 1'b1;
`endif
    end else begin
      sel = data_sram_en;
    end
  end

  assign full      = (count_q == FULL_CNT);
  assign sram_en   = (inst_sram_en | data_sram_en) & ~full;
  assign push      = sram_en & sram_addr_ok;
  // A response with nothing outstanding is a slave protocol error and is ignored.
  assign pop       = sram_data_ok & (count_q != '0);
  assign head      = fifo_q[rd_ptr_q];
  assign locked_en = lock_id_q ? data_sram_en : inst_sram_en;

  // The inst port is read-only, so its write fields are forced to zero.
  assign sram_wr    = sel ? data_sram_wr    : 1'b0;
  assign sram_we    = sel ? data_sram_we    : 4'b0;
  assign sram_wdata = sel ? data_sram_wdata : 32'b0;
  assign sram_size  = sel ? data_sram_size  : inst_sram_size;
  assign sram_addr  = sel ? data_sram_addr  : inst_sram_addr;

  assign inst_sram_addr_ok = push & ~sel;
  assign data_sram_addr_ok = push & sel;
  assign inst_sram_data_ok = pop & ~head;
  assign data_sram_data_ok = pop & head;
  assign inst_sram_rdata   = sram_rdata;
  assign data_sram_rdata   = sram_rdata;

  // Next state for the order FIFO, the grant lock and the round-robin history.
  always_comb begin
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fifo_d    = fifo_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
`ifdef ARB_RR_EN
    rr_last_d = push ? sel : rr_last_q;
`endif
    if (push) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    // Lock keeps the request fields stable at the slave until it takes the address;
    // a cancelled request (en dropped) releases it.
    if (sram_addr_ok) begin
      lock_d = 1'b0;
    end else if (lock_q && !locked_en) begin
      lock_d = 1'b0;
    end else if (sram_en && !lock_q) begin
      lock_d    = 1'b1;
      lock_id_d = sel;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fifo_q    <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
`ifdef ARB_RR_EN
      rr_last_q <= 1'b0;
`endif
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fifo_q    <= fifo_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
`ifdef ARB_RR_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// tb/tb_cpu_sram_arbiter.sv - scoreboard bench for cpu_sram_arbiter
module tb_cpu_sram_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_en;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        sram_en, sram_wr;
  logic [1:0]  sram_size;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr, sram_wdata;
  logic        sram_addr_ok, sram_data_ok;
  logic [31:0] sram_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        owner;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  cpu_sram_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_en(inst_sram_en), .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .sram_en(sram_en), .sram_wr(sram_wr), .sram_size(sram_size), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_addr_ok(sram_addr_ok),
    .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic owner, input logic [31:0] rdata);
    exp_t r;
    r.owner = owner;
    r.rdata = rdata;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_sram_en = 0; inst_sram_size = 2'd2; inst_sram_addr = '0;
    data_sram_en = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_we = '0;
    data_sram_addr = '0; data_sram_wdata = '0;
    sram_addr_ok = 0; sram_data_ok = 0; sram_rdata = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut.count_q !== 3'd0 || dut.lock_q !== 1'b0) begin
      errors++; $display("FAIL reset_state: count=%0d lock=%b required 0/0", dut.count_q, dut.lock_q);
    end
    checks++;
    if ({sram_en, inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: en/aok/dok=%b required 00000",
        {sram_en, inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok});
    end
    reset = 0;
    tick();
  endtask

  task automatic test_single_inst();
    inst_sram_en = 1; inst_sram_addr = 32'h1c000000; sram_addr_ok = 1;
    @(negedge clk);
    checks++;
    if ({sram_en, inst_sram_addr_ok, data_sram_addr_ok} !== 3'b110) begin
      errors++; $display("FAIL single_grant: en/iaok/daok=%b required 110", {sram_en, inst_sram_addr_ok, data_sram_addr_ok});
    end
    checks++;
    if (sram_addr !== 32'h1c000000 || sram_wr !== 1'b0 || sram_we !== 4'h0) begin
      errors++; $display("FAIL single_fields: addr=%h wr=%b we=%h required 1c000000/0/0", sram_addr, sram_wr, sram_we);
    end
    sb.push_back(mk(1'b0, 32'h02800c0c));
    tick();
    inst_sram_en = 0; sram_addr_ok = 0;
    @(negedge clk);
    checks++;
    if (inst_sram_addr_ok !== 1'b0) begin
      errors++; $display("FAIL single_pulse: iaok=%b required 0", inst_sram_addr_ok);
    end
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front(); sram_data_ok = 1; sram_rdata = e.rdata;
      @(negedge clk);
      checks++;
      if ({inst_sram_data_ok, data_sram_data_ok} !== {~e.owner, e.owner} || inst_sram_rdata !== e.rdata) begin
        errors++; $display("FAIL single_resp: idok/ddok=%b rdata=%h required %b/%h",
          {inst_sram_data_ok, data_sram_data_ok}, inst_sram_rdata, {~e.owner, e.owner}, e.rdata);
      end
      tick();
    end
    sram_data_ok = 0;
  endtask

  task automatic test_contention_lock();
    logic exp_sel;
    inst_sram_en = 1; inst_sram_addr = 32'h1c000100;
    data_sram_en = 1; data_sram_wr = 1; data_sram_we = 4'hf;
    data_sram_addr = 32'h00000200; data_sram_wdata = 32'hdeadbeef;
    sram_addr_ok = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (sram_addr !== 32'h200 || inst_sram_addr_ok !== 1'b0 || data_sram_addr_ok !== 1'b0) begin
        errors++; $display("FAIL lock_hold[%0d]: addr=%h iaok=%b daok=%b required 00000200/0/0",
          i, sram_addr, inst_sram_addr_ok, data_sram_addr_ok);
      end
      tick();
    end
    checks++;
    if (dut.lock_q !== 1'b1 || dut.lock_id_q !== 1'b1) begin
      errors++; $display("FAIL lock_set: lock=%b id=%b required 1/1", dut.lock_q, dut.lock_id_q);
    end
    sram_addr_ok = 1;
    @(negedge clk);
    checks++;
    if (data_sram_addr_ok !== 1'b1 || sram_wr !== 1'b1 || sram_we !== 4'hf || sram_wdata !== 32'hdeadbeef) begin
      errors++; $display("FAIL data_grant: daok=%b wr=%b we=%h wdata=%h required 1/1/f/deadbeef",
        data_sram_addr_ok, sram_wr, sram_we, sram_wdata);
    end
    sb.push_back(mk(1'b1, 32'h11110001));
    tick();
    data_sram_en = 0;
    @(negedge clk);
    checks++;
    if (inst_sram_addr_ok !== 1'b1 || sram_addr !== 32'h1c000100 || sram_wdata !== 32'h0 || sram_we !== 4'h0) begin
      errors++; $display("FAIL inst_after: iaok=%b addr=%h wdata=%h we=%h required 1/1c000100/0/0",
        inst_sram_addr_ok, sram_addr, sram_wdata, sram_we);
    end
    sb.push_back(mk(1'b0, 32'h22220002));
    tick();
    data_sram_en = 1; data_sram_wr = 0; data_sram_we = 4'h0; data_sram_addr = 32'h00000300;
    @(negedge clk);
    checks++;
    if (data_sram_addr_ok !== 1'b1 || inst_sram_addr_ok !== 1'b0) begin
      errors++; $display("FAIL contend1: iaok/daok=%b%b required 01", inst_sram_addr_ok, data_sram_addr_ok);
    end
    sb.push_back(mk(1'b1, 32'h33330003));
    tick();
`ifdef ARB_RR_EN
    exp_sel = 1'b0;
`else
    exp_sel = 1'b1;
`endif
    @(negedge clk);
    checks++;
    if ({inst_sram_addr_ok, data_sram_addr_ok} !== {~exp_sel, exp_sel}) begin
      errors++; $display("FAIL contend2: iaok/daok=%b%b required %b%b",
        inst_sram_addr_ok, data_sram_addr_ok, ~exp_sel, exp_sel);
    end
    sb.push_back(mk(exp_sel, 32'h44440004));
    tick();
    idle();
    while (sb.size() > 0) begin
      e = sb.pop_front(); sram_data_ok = 1; sram_rdata = e.rdata;
      @(negedge clk);
      checks++;
      if ({inst_sram_data_ok, data_sram_data_ok} !== {~e.owner, e.owner} || data_sram_rdata !== e.rdata) begin
        errors++; $display("FAIL contend_resp: idok/ddok=%b rdata=%h required %b/%h",
          {inst_sram_data_ok, data_sram_data_ok}, data_sram_rdata, {~e.owner, e.owner}, e.rdata);
      end
      tick();
    end
    sram_data_ok = 0;
    // Lock owned by inst must beat data priority; a cancel releases it.
    inst_sram_en = 1; inst_sram_addr = 32'h1c000200;
    tick();
    data_sram_en = 1; data_sram_addr = 32'h00000400;
    @(negedge clk);
    checks++;
    if (sram_addr !== 32'h1c000200 || dut.lock_q !== 1'b1 || dut.lock_id_q !== 1'b0) begin
      errors++; $display("FAIL lock_inst: addr=%h lock=%b id=%b required 1c000200/1/0",
        sram_addr, dut.lock_q, dut.lock_id_q);
    end
    tick();
    inst_sram_en = 0;
    tick();
    checks++;
    if (dut.lock_q !== 1'b0) begin
      errors++; $display("FAIL lock_cancel: lock=%b required 0", dut.lock_q);
    end
    sram_addr_ok = 1;
    @(negedge clk);
    checks++;
    if (data_sram_addr_ok !== 1'b1 || sram_addr !== 32'h400) begin
      errors++; $display("FAIL after_cancel: daok=%b addr=%h required 1/00000400", data_sram_addr_ok, sram_addr);
    end
    sb.push_back(mk(1'b1, 32'h55550005));
    tick();
    idle();
    while (sb.size() > 0) begin
      e = sb.pop_front(); sram_data_ok = 1; sram_rdata = e.rdata;
      @(negedge clk);
      checks++;
      if ({inst_sram_data_ok, data_sram_data_ok} !== {~e.owner, e.owner}) begin
        errors++; $display("FAIL cancel_resp: idok/ddok=%b required %b",
          {inst_sram_data_ok, data_sram_data_ok}, {~e.owner, e.owner});
      end
      tick();
    end
    sram_data_ok = 0;
  endtask

  task automatic test_ordering();
    logic [2:0] owners;
    owners = 3'b010;
    sram_addr_ok = 1;
    for (int i = 0; i < 3; i++) begin
      inst_sram_en = ~owners[i]; data_sram_en = owners[i];
      inst_sram_addr = 32'h1c001000 + 32'(i * 4); data_sram_addr = 32'h00001000 + 32'(i * 4);
      @(negedge clk);
      checks++;
      if ({inst_sram_addr_ok, data_sram_addr_ok} !== {~owners[i], owners[i]}) begin
        errors++; $display("FAIL order_issue[%0d]: iaok/daok=%b%b required %b%b",
          i, inst_sram_addr_ok, data_sram_addr_ok, ~owners[i], owners[i]);
      end
      sb.push_back(mk(owners[i], 32'h66660000 + 32'(i)));
      tick();
    end
    idle();
    while (sb.size() > 0) begin
      e = sb.pop_front(); sram_data_ok = 1; sram_rdata = e.rdata;
      @(negedge clk);
      checks++;
      if ({inst_sram_data_ok, data_sram_data_ok} !== {~e.owner, e.owner} || inst_sram_rdata !== e.rdata) begin
        errors++; $display("FAIL order_resp: idok/ddok=%b rdata=%h required %b/%h",
          {inst_sram_data_ok, data_sram_data_ok}, inst_sram_rdata, {~e.owner, e.owner}, e.rdata);
      end
      tick();
    end
    sram_data_ok = 0;
  endtask

  task automatic test_full();
    sram_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      inst_sram_en = ((i % 2) == 0); data_sram_en = ((i % 2) != 0);
      inst_sram_addr = 32'h1c002000; data_sram_addr = 32'h00002000;
      @(negedge clk);
      sb.push_back(mk(data_sram_en, 32'h77770000 + 32'(i)));
      tick();
    end
    checks++;
    if (dut.count_q !== 3'd4) begin
      errors++; $display("FAIL full_count: count=%0d required 4", dut.count_q);
    end
    inst_sram_en = 1; data_sram_en = 1;
    @(negedge clk);
    checks++;
    if ({sram_en, inst_sram_addr_ok, data_sram_addr_ok} !== 3'b000) begin
      errors++; $display("FAIL full_block: en/iaok/daok=%b required 000", {sram_en, inst_sram_addr_ok, data_sram_addr_ok});
    end
    tick();
    e = sb.pop_front(); sram_data_ok = 1; sram_rdata = e.rdata;
    @(negedge clk);
    checks++;
    if (sram_en !== 1'b0 || {inst_sram_data_ok, data_sram_data_ok} !== {~e.owner, e.owner}) begin
      errors++; $display("FAIL full_pop: en=%b idok/ddok=%b required 0/%b",
        sram_en, {inst_sram_data_ok, data_sram_data_ok}, {~e.owner, e.owner});
    end
    tick();
    sram_data_ok = 0; inst_sram_en = 0;
    @(negedge clk);
    checks++;
    if (sram_en !== 1'b1 || data_sram_addr_ok !== 1'b1) begin
      errors++; $display("FAIL full_resume: en=%b daok=%b required 1/1", sram_en, data_sram_addr_ok);
    end
    sb.push_back(mk(1'b1, 32'h77770010));
    tick();
    idle();
    checks++;
    if (dut.count_q !== 3'd4) begin
      errors++; $display("FAIL full_refill: count=%0d required 4", dut.count_q);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); sram_data_ok = 1; sram_rdata = e.rdata;
      @(negedge clk);
      checks++;
      if ({inst_sram_data_ok, data_sram_data_ok} !== {~e.owner, e.owner} || data_sram_rdata !== e.rdata) begin
        errors++; $display("FAIL full_resp: idok/ddok=%b rdata=%h required %b/%h",
          {inst_sram_data_ok, data_sram_data_ok}, data_sram_rdata, {~e.owner, e.owner}, e.rdata);
      end
      tick();
    end
    sram_data_ok = 0;
  endtask

  task automatic test_push_pop_wrap();
    logic own;
    sram_addr_ok = 1;
    for (int i = 0; i < 2; i++) begin
      inst_sram_en = (i == 0); data_sram_en = (i != 0);
      sb.push_back(mk(data_sram_en, 32'h88880000 + 32'(i)));
      tick();
    end
    checks++;
    if (dut.count_q !== 3'd2) begin
      errors++; $display("FAIL pp_pre: count=%0d required 2", dut.count_q);
    end
    for (int i = 0; i < 7; i++) begin
      own = 1'($urandom_range(0, 1));
      inst_sram_en = ~own; data_sram_en = own;
      e = sb.pop_front(); sram_data_ok = 1; sram_rdata = e.rdata;
      @(negedge clk);
      checks++;
      if ({inst_sram_data_ok, data_sram_data_ok} !== {~e.owner, e.owner} ||
          {inst_sram_addr_ok, data_sram_addr_ok} !== {~own, own}) begin
        errors++; $display("FAIL pp_route[%0d]: dok=%b aok=%b required %b/%b", i,
          {inst_sram_data_ok, data_sram_data_ok}, {inst_sram_addr_ok, data_sram_addr_ok},
          {~e.owner, e.owner}, {~own, own});
      end
      sb.push_back(mk(own, 32'h99990000 + 32'(i)));
      tick();
      checks++;
      if (dut.count_q !== 3'd2) begin
        errors++; $display("FAIL pp_count[%0d]: count=%0d required 2", i, dut.count_q);
      end
    end
    idle();
    while (sb.size() > 0) begin
      e = sb.pop_front(); sram_data_ok = 1; sram_rdata = e.rdata;
      @(negedge clk);
      checks++;
      if ({inst_sram_data_ok, data_sram_data_ok} !== {~e.owner, e.owner}) begin
        errors++; $display("FAIL pp_drain: idok/ddok=%b required %b",
          {inst_sram_data_ok, data_sram_data_ok}, {~e.owner, e.owner});
      end
      tick();
    end
    sram_data_ok = 0;
  endtask

  task automatic test_reset_midflight();
    sram_addr_ok = 1; inst_sram_en = 1;
    for (int i = 0; i < 3; i++) begin
      inst_sram_addr = 32'h1c003000 + 32'(i * 4);
      tick();
    end
    inst_sram_en = 0; data_sram_en = 1; data_sram_addr = 32'h00003000; sram_addr_ok = 0;
    tick();
    checks++;
    if (dut.count_q !== 3'd3 || dut.lock_q !== 1'b1) begin
      errors++; $display("FAIL rst_pre: count=%0d lock=%b required 3/1", dut.count_q, dut.lock_q);
    end
    #3;
    reset = 1;
    #1;
    checks++;
    if (dut.count_q !== 3'd0 || dut.lock_q !== 1'b0) begin
      errors++; $display("FAIL rst_async: count=%0d lock=%b required 0/0", dut.count_q, dut.lock_q);
    end
    sb.delete();
    idle();
    #2;
    reset = 0;
    tick();
    sram_data_ok = 1; sram_rdata = 32'hbad0bad0;
    @(negedge clk);
    checks++;
    if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin
      errors++; $display("FAIL stray_resp: idok/ddok=%b required 00", {inst_sram_data_ok, data_sram_data_ok});
    end
    tick();
    sram_data_ok = 0;
    checks++;
    if (dut.count_q !== 3'd0) begin
      errors++; $display("FAIL stray_count: count=%0d required 0", dut.count_q);
    end
  endtask

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_single_inst();
    test_contention_lock();
    test_ordering();
    test_full();
    test_push_pop_wrap();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sram_arbiter.md
# cpu_sram_arbiter

Shares one SRAM-like slave port between the instruction-fetch requester (pre-IF) and the data requester (EXE/MEM). Each cycle it grants at most one request, holds that grant until the slave accepts the address, and records the owner of every accepted request in an order FIFO. Each `data_ok` is routed back to the requester at the FIFO head. It sits between the pipeline's inst/data SRAM-like ports and the single SRAM-like port that feeds the AXI bridge.

## Interface
Parameters:
- `DEPTH`, default 4: maximum outstanding accepted-but-unreturned requests (power of 2, 2..16).
- `PTR_W`, default 2: log2(DEPTH).

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `inst_sram_en` in 1: inst request valid; read-only.
- `inst_sram_size` in 2: inst access size.
- `inst_sram_addr` in 32: inst address.
- `inst_sram_addr_ok` out 1: inst address accepted.
- `inst_sram_data_ok` out 1: inst read data valid.
- `inst_sram_rdata` out 32: inst read data.
- `data_sram_en` in 1: data request valid.
- `data_sram_wr` in 1: 1 = write.
- `data_sram_size` in 2: data access size.
- `data_sram_we` in 4: data byte enables.
- `data_sram_addr` in 32: data address.
- `data_sram_wdata` in 32: data write data.
- `data_sram_addr_ok` out 1: data address accepted.
- `data_sram_data_ok` out 1: data read data valid or write done.
- `data_sram_rdata` out 32: data read data.
- `sram_en` out 1: request to slave.
- `sram_wr` out 1: write flag to slave.
- `sram_size` out 2: size to slave.
- `sram_we` out 4: byte enables to slave.
- `sram_addr` out 32: address to slave.
- `sram_wdata` out 32: write data to slave.
- `sram_addr_ok` in 1: slave accepted the address this cycle.
- `sram_data_ok` in 1: slave returns a response this cycle.
- `sram_rdata` in 32: slave read data.

## Operation
- **Grant selection:** combinational. Owner `sel` is 0 = inst, 1 = data.
  - If `lock` is set, `sel = lock_id`.
  - Otherwise, if exactly one requester is asserting, that requester wins.
  - If both are asserting, data wins (fixed priority; see Configuration).
- **Blocking:** `sram_en = (inst_sram_en | data_sram_en) & ~full`.
- **Request muxing:** the slave request fields are muxed from `sel`. When inst is selected, `sram_wr = 0`, `sram_we = 0` and `sram_wdata = 0`.
- **Address handshake routing:** `inst_sram_addr_ok = sram_en & sram_addr_ok & (sel==0)`. `data_sram_addr_ok` is the same term with `sel==1`.
- **Lock:**
  - Set when `sram_en & ~sram_addr_ok` and no lock is held; `lock_id <= sel`.
  - Cleared on `sram_addr_ok`.
  - While a lock is held, the locked requester keeps the grant even if the other requester has higher priority.
  - If the locked requester drops its `en`, the lock clears the next cycle. Pipeline cancels may do this.
- **Order FIFO:**
  - Each entry is 1 bit (the owner id).
  - Push on `sram_en & sram_addr_ok`. Pop on `sram_data_ok`.
  - `count` is `PTR_W+1` bits wide; the pointers wrap modulo `DEPTH`.
  - `full = (count == DEPTH)`.
- **Response routing:**
  - `inst_sram_data_ok = sram_data_ok & (head==0)`; `data_sram_data_ok = sram_data_ok & (head==1)`.
  - `sram_rdata` is broadcast to both `*_rdata` outputs.
  - `sram_data_ok` while the FIFO is empty is a protocol error: it is dropped, `count` stays 0, and no `data_ok` is raised.
- **Simultaneous push and pop:** `count` is unchanged and both pointers advance.
- **Full with a pop in the same cycle:** `full` is evaluated on the registered `count`, so a push is still blocked in that cycle. The request is granted the next cycle.

## Timing
- **Reset values:** `count = 0`, pointers = 0, `lock = 0`, `rr_last = 0`. All handshake outputs are 0 while the requesters' `en` inputs are 0.
- **Latency:** zero-cycle request path; requester `en` to `sram_en` is combinational. `sram_addr_ok` and `sram_data_ok` are forwarded combinationally.
- **FIFO and lock updates:** take effect at the next rising edge.
- **Reset mid-transaction:** asserting `reset` clears the FIFO and the lock immediately. Responses still in flight at the slave are dropped. System reset of the slave is required together with this block.
- **Requester obligation:** each requester holds all request fields stable from `en` until its own `addr_ok`.

## Configuration
- `ARB_RR_EN` defined: round-robin priority when both requesters assert with no lock held. The requester other than `rr_last` wins. `rr_last` updates to `sel` on every push.
- `ARB_RR_EN` undefined: fixed data-over-inst priority and no `rr_last` register.

## Test plan
- **Single inst read:** `inst_sram_en = 1`, `addr = 0x1c000000`, slave `addr_ok` in the same cycle, `data_ok` 2 cycles later with rdata `0x02800c0c` -> one `inst_sram_addr_ok` pulse, then `inst_sram_data_ok = 1` with rdata `0x02800c0c`, and `data_sram_data_ok` stays 0.
- **Contention and lock:**
  - Both requesters assert in the same cycle and the slave delays `addr_ok` by 3 cycles -> data is granted (fixed priority), the lock holds `sram_addr` = data addr for all 3 cycles, then inst is granted.
  - With `ARB_RR_EN`, a second contention after a data grant -> inst wins.
- **Ordering:** issue inst, data, inst with slave responses in order -> `data_ok` is routed inst, data, inst in that order.
- **Full:**
  - `DEPTH = 4` and 4 pushes without responses -> `sram_en` = 0 while both requesters assert.
  - One `sram_data_ok` -> the next cycle a grant resumes and `count` returns to 4.
- **Push and pop together:** at `count = 2`, push and pop in the same cycle -> `count` remains 2. Wrap the pointers past index 3 and check that owners are still routed correctly.
- **Reset and stray response:**
  - Async `reset` pulsed mid-cycle with 3 requests outstanding -> `count = 0` and `lock = 0` immediately.
  - A stray `sram_data_ok` afterwards -> no `*_data_ok` output asserts.
